// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset address,
// FSM state encoding and the word-alignment helper.
package pc_fetch_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // FETCH: a memory request is outstanding. HOLD: no request in flight.
   typedef enum logic {
      S_HOLD  = 1'b0,
      S_FETCH = 1'b1
   } fetch_state_e;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the memory (slave).
interface pc_fetch_if;
   import pc_fetch_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;

   modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
   modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/pc_fetch_if_buf.sv
// One-entry valid/ready output register feeding decode; a flush hides the
// entry immediately and empties it on the next edge.
module if_buf
   import pc_fetch_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            load,
   input  logic [XLEN-1:0] load_instr,
   input  logic [XLEN-1:0] load_pc,
   input  logic            ready,
   output logic            valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc
);

   logic valid_q;

   assign valid = valid_q & ~flush;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         instr   <= '0;
         pc      <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         instr   <= load_instr;
         pc      <= load_pc;
      end else if (valid && ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: keeps one memory request in flight, buffers the returned
// word for decode, and handles redirects by squashing in-flight data.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ena,
   input  logic            pc_wr,
   input  logic [XLEN-1:0] pc_in,
   pc_fetch_if.master      imem,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   input  logic            if_ready,
   output logic            misalign
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] target_q;
   logic            squash_q;
   logic            misalign_q;
   logic            req;
   logic            redirect;
   logic            issue;
   logic            accept;
   logic            buf_load;

   assign redirect = pc_wr & ena;
   // A new request may start only if its ack can land in the buffer.
   assign issue    = ena & ~redirect & (~if_valid | if_ready);
   assign accept   = req & imem.imem_ack;
   assign buf_load = accept & ~squash_q & ~redirect;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d = state_q;
      req     = 1'b0;
      case (state_q)
         S_HOLD: begin
            if (issue) begin
               req = 1'b1;
               if (!imem.imem_ack) state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            req = 1'b1;
            if (imem.imem_ack) state_d = S_HOLD;
         end
      endcase
      if (reset) req = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_HOLD;
         pc_q       <= RESET_PC;
         target_q   <= RESET_PC;
         squash_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         misalign_q <= redirect & (pc_in[1:0] != 2'b00);
         if (redirect) begin
            // imem_addr must not move under an unacked request: park the target.
            if (state_q == S_FETCH && !imem.imem_ack) begin
               squash_q <= 1'b1;
               target_q <= align_pc(pc_in);
            end else begin
               squash_q <= 1'b0;
               pc_q     <= align_pc(pc_in);
            end
         end else if (accept) begin
            squash_q <= 1'b0;
            pc_q     <= squash_q ? target_q : pc_q + XLEN'(INSTR_BYTES);
         end
      end
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = pc_q;
   assign misalign       = misalign_q;

   if_buf u_if_buf (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect),
      .load       (buf_load),
      .load_instr (imem.imem_rdata),
      .load_pc    (pc_q),
      .ready      (if_ready),
      .valid      (if_valid),
      .instr      (if_instr),
      .pc         (if_pc)
   );

endmodule

// File: tb/tb_pc_fetch.sv
// Directed and randomized bench for pc_fetch: a latency-programmable memory
// model plus an instruction-stream model of what decode must receive.
module tb_pc_fetch;
   import pc_fetch_pkg::*;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, ena, pc_wr, if_ready;
   logic [31:0] pc_in;
   logic        if_valid, misalign;
   logic [31:0] if_instr, if_pc;

   pc_fetch_if imem ();

   pc_fetch dut (
      .clk      (clk),
      .reset    (reset),
      .ena      (ena),
      .pc_wr    (pc_wr),
      .pc_in    (pc_in),
      .imem     (imem),
      .if_valid (if_valid),
      .if_instr (if_instr),
      .if_pc    (if_pc),
      .if_ready (if_ready),
      .misalign (misalign)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // memory model state
   bit          mem_busy = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_wait = 0;
   int          lat_cfg  = 0;
   bit          lat_rand = 1'b0;

   // instruction-stream model state
   logic [31:0] model_pc  = TB_RESET_PC;
   bit          exp_mis   = 1'b0;
   bit          prev_hold = 1'b0;
   int          xfer_cnt  = 0;

   // snapshot of DUT outputs taken mid-cycle
   logic        obs_req, obs_valid, obs_mis;
   logic [31:0] obs_addr, obs_pc, obs_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %b required %b", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, answer the memory, check, then advance.
   task automatic run_cycle(input logic e, input logic w, input logic [31:0] pi, input logic rdy);
      logic redir;
      ena = e; pc_wr = w; pc_in = pi; if_ready = rdy;
      #1;
      if (reset) begin
         mem_busy        = 1'b0;
         imem.imem_ack   = 1'b0;
         imem.imem_rdata = '0;
      end else begin
         if (mem_busy) begin
            check_bit("req_held", imem.imem_req, 1'b1);
            check("addr_stable", imem.imem_addr, mem_addr);
         end else if (imem.imem_req === 1'b1) begin
            mem_busy = 1'b1;
            mem_addr = imem.imem_addr;
            mem_wait = lat_rand ? int'($urandom_range(0, 2)) : lat_cfg;
            check("addr_align", {30'b0, imem.imem_addr[1:0]}, 32'h0);
         end
         imem.imem_ack   = mem_busy && (mem_wait == 0);
         imem.imem_rdata = imem.imem_ack ? mem_word(mem_addr) : $urandom();
      end
      #1;
      obs_req = imem.imem_req; obs_addr = imem.imem_addr; obs_valid = if_valid;
      obs_pc  = if_pc;         obs_instr = if_instr;      obs_mis = misalign;
      redir = e && w && !reset;
      if (!reset) begin
         check_bit("misalign", misalign, exp_mis);
         if (redir) check_bit("redirect_kills_valid", if_valid, 1'b0);
         else if (prev_hold) check_bit("hold_valid", if_valid, 1'b1);
         if (if_valid) begin
            check("stream_pc", if_pc, model_pc);
            check("stream_instr", if_instr, mem_word(model_pc));
            if (rdy) begin
               model_pc += 32'd4;
               xfer_cnt++;
            end
         end
         if (redir) model_pc = {pi[31:2], 2'b00};
         exp_mis   = redir && (pi[1:0] != 2'b00);
         prev_hold = if_valid && !rdy && !redir;
      end else begin
         model_pc  = TB_RESET_PC;
         exp_mis   = 1'b0;
         prev_hold = 1'b0;
      end
      if (imem.imem_ack) mem_busy = 1'b0;
      else if (mem_busy) mem_wait--;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ena = 1'b0; pc_wr = 1'b0; pc_in = '0; if_ready = 1'b0;
      imem.imem_ack = 1'b0; imem.imem_rdata = '0;
      @(posedge clk);
      #1;

      // reset values
      do_reset(2);
      check_bit("rst_req", obs_req, 1'b0);
      check("rst_addr", obs_addr, TB_RESET_PC);
      check_bit("rst_valid", obs_valid, 1'b0);
      check_bit("rst_mis", obs_mis, 1'b0);
      check("rst_instr", obs_instr, 32'h0);
      check("rst_pc", obs_pc, 32'h0);

      // first fetch after reset, then one instruction per cycle
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_bit("first_req", obs_req, 1'b1);
      check("first_addr", obs_addr, TB_RESET_PC);
      check_bit("first_valid", obs_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
         check_bit("seq_valid", obs_valid, 1'b1);
         check("seq_pc", obs_pc, 32'(4 * i));
      end

      // decode stalls three cycles with the buffer full
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
         check_bit("stall_req", obs_req, 1'b0);
         check_bit("stall_valid", obs_valid, 1'b1);
         check("stall_pc", obs_pc, 32'h10);
      end
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check("release_pc", obs_pc, 32'h10);
      check("release_addr", obs_addr, 32'h14);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check("release_next_pc", obs_pc, 32'h14);

      // redirect while a slow request is outstanding squashes its data
      lat_cfg = 2;
      run_cycle(1'b1, 1'b1, 32'h10, 1'b1);
      check_bit("redir_valid_low", obs_valid, 1'b0);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_bit("slow_req", obs_req, 1'b1);
      check("slow_addr", obs_addr, 32'h10);
      run_cycle(1'b1, 1'b1, 32'h200, 1'b1);
      check("wait_addr", obs_addr, 32'h10);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_bit("squash_ack_valid", obs_valid, 1'b0);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_bit("target_req", obs_req, 1'b1);
      check("target_addr", obs_addr, 32'h200);
      check_bit("squashed_never_valid", obs_valid, 1'b0);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_bit("target_wait_valid", obs_valid, 1'b0);
      lat_cfg = 0;
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_bit("target_valid", obs_valid, 1'b1);
      check("target_pc", obs_pc, 32'h200);

      // misaligned redirect
      run_cycle(1'b1, 1'b1, 32'h103, 1'b1);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_bit("misalign_pulse", obs_mis, 1'b1);
      check("misalign_addr", obs_addr, 32'h100);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_bit("misalign_end", obs_mis, 1'b0);

      // address wrap
      run_cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check("wrap_top_addr", obs_addr, 32'hFFFF_FFFC);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check("wrap_addr", obs_addr, 32'h0000_0000);
      check("wrap_top_pc", obs_pc, 32'hFFFF_FFFC);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check("wrap_pc", obs_pc, 32'h0000_0000);

      // ena low neither aborts a request nor captures a redirect
      lat_cfg = 2;
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check("ena_start_addr", obs_addr, 32'h8);
      run_cycle(1'b0, 1'b1, 32'h301, 1'b1);
      check_bit("ena_low_req", obs_req, 1'b1);
      run_cycle(1'b0, 1'b1, 32'h301, 1'b1);
      check_bit("ena_low_no_mis", obs_mis, 1'b0);
      run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_bit("ena_low_valid", obs_valid, 1'b1);
      check("ena_low_pc", obs_pc, 32'h8);
      check_bit("ena_low_no_issue", obs_req, 1'b0);

      // reset in the middle of an outstanding request
      run_cycle(1'b1, 1'b1, 32'h40, 1'b1);
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check("pre_reset_addr", obs_addr, 32'h40);
      do_reset(2);
      check_bit("mid_rst_req", obs_req, 1'b0);
      check("mid_rst_addr", obs_addr, TB_RESET_PC);
      check_bit("mid_rst_valid", obs_valid, 1'b0);
      check("mid_rst_pc", obs_pc, 32'h0);
      lat_cfg = 0;
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_bit("post_rst_req", obs_req, 1'b1);
      check("post_rst_addr", obs_addr, TB_RESET_PC);

      // randomized traffic against the stream model
      lat_rand = 1'b1;
      xfer_cnt = 0;
      for (int i = 0; i < 600; i++) begin
         run_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
                   $urandom(), $urandom_range(0, 3) != 0);
      end
      check_bit("random_progress", xfer_cnt > 60, 1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
